// File: rtl/vga_fetch.sv
// Framebuffer fetch master for the VGA bus port: one outstanding read at a time,
// words pushed into a show-ahead FIFO that the pixel generator drains.

module vga_fetch #(
    parameter int FIFO_AW         = 4,
    parameter int WORDS_PER_FRAME = 76800,
    parameter int LOW_WATER       = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [31:0]        fb_base,
    input  logic               enable,
    input  logic               frame_start,
    output logic [31:0]        bus_address,
    output logic               bus_read,
    input  logic               bus_wait,
    input  logic [31:0]        bus_readdata,
    input  logic               pix_rd,
    output logic [31:0]        pix_data,
    output logic               pix_valid,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               starving,
    output logic               underflow
);

    localparam int                DEPTH      = 1 << FIFO_AW;
    localparam int                CNT_W      = $clog2(WORDS_PER_FRAME + 1);
    localparam logic [CNT_W-1:0]  WORDS_LAST = CNT_W'(WORDS_PER_FRAME);
    localparam logic [FIFO_AW:0]  LEVEL_FULL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]  LEVEL_LOW  = (FIFO_AW + 1)'(LOW_WATER);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   word_cnt;
    logic [CNT_W-1:0]   word_cnt_nxt;
    logic [31:0]        addr_nxt;
    logic               read_nxt;
    logic               push;
    logic               pop;

    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [31:0]        mem [DEPTH];

    // Next-state: frame_start overrides everything, abandoning any in-flight read.
    always_comb begin
        state_nxt    = state;
        read_nxt     = bus_read;
        addr_nxt     = bus_address;
        word_cnt_nxt = word_cnt;
        push         = 1'b0;
        if (frame_start) begin
            state_nxt    = IDLE;
            read_nxt     = 1'b0;
            addr_nxt     = fb_base;
            word_cnt_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    // No word is in flight here, so the level alone bounds FIFO space.
                    if (enable && (word_cnt < WORDS_LAST) && (fifo_level < LEVEL_FULL)) begin
                        state_nxt = REQ;
                        read_nxt  = 1'b1;
                    end
                end
                REQ: begin
                    if (!bus_wait) begin
                        push         = 1'b1;
                        read_nxt     = 1'b0;
                        addr_nxt     = bus_address + 32'd1;
                        word_cnt_nxt = word_cnt + CNT_W'(1);
                        state_nxt    = RELEASE;
                    end
                end
                RELEASE: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            bus_read    <= 1'b0;
            bus_address <= '0;
            word_cnt    <= WORDS_LAST;
        end else begin
            state       <= state_nxt;
            bus_read    <= read_nxt;
            bus_address <= addr_nxt;
            word_cnt    <= word_cnt_nxt;
        end
    end

    assign pop = pix_rd && pix_valid && !frame_start;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            underflow  <= 1'b0;
        end else if (frame_start) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            underflow  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
            if (pix_rd && !pix_valid) begin
                underflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= bus_readdata;
        end
    end

    assign pix_data  = mem[rd_ptr];
    assign pix_valid = (fifo_level != '0);
    assign starving  = (fifo_level <= LEVEL_LOW) && (word_cnt < WORDS_LAST);

endmodule

// File: tb/tb_vga_fetch.sv
// Randomised bench for vga_fetch: bus slave model, pixel-side popper and a
// queue-based reference of the fetch stream compared every cycle.

module tb_vga_fetch;

    localparam int FIFO_AW   = 4;
    localparam int WPF       = 20;
    localparam int LOW_WATER = 4;
    localparam int DEPTH     = 16;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic [31:0]        fb_base = '0;
    logic               enable = 1'b0;
    logic               frame_start = 1'b0;
    logic [31:0]        bus_address;
    logic               bus_read;
    logic               bus_wait = 1'b0;
    logic [31:0]        bus_readdata = '0;
    logic               pix_rd = 1'b0;
    logic [31:0]        pix_data;
    logic               pix_valid;
    logic [FIFO_AW:0]   fifo_level;
    logic               starving;
    logic               underflow;

    vga_fetch #(
        .FIFO_AW        (FIFO_AW),
        .WORDS_PER_FRAME(WPF),
        .LOW_WATER      (LOW_WATER)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .fb_base      (fb_base),
        .enable       (enable),
        .frame_start  (frame_start),
        .bus_address  (bus_address),
        .bus_read     (bus_read),
        .bus_wait     (bus_wait),
        .bus_readdata (bus_readdata),
        .pix_rd       (pix_rd),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .fifo_level   (fifo_level),
        .starving     (starving),
        .underflow    (underflow)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Reference model: FIFO contents, frame progress and next expected address.
    logic [31:0] q[$];
    logic [31:0] addr_log[$];
    bit          m_under = 1'b0;
    int          m_words = WPF;
    logic [31:0] m_addr = '0;
    bit          may_req = 1'b0;
    bit          last_complete = 1'b0;
    bit          last_push_ok = 1'b1;
    bit          last_fs = 1'b0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            m_under       <= 1'b0;
            m_words       <= WPF;
            m_addr        <= '0;
            may_req       <= 1'b0;
            last_complete <= 1'b0;
            last_push_ok  <= 1'b1;
            last_fs       <= 1'b0;
        end else begin
            may_req       <= enable && (m_words < WPF) && (q.size() < DEPTH) && !frame_start;
            last_complete <= bus_read && !bus_wait && !frame_start;
            last_push_ok  <= (q.size() < DEPTH);
            last_fs       <= frame_start;
            if (frame_start) begin
                q.delete();
                m_under <= 1'b0;
                m_words <= 0;
                m_addr  <= fb_base;
            end else begin
                if (pix_rd) begin
                    if (q.size() > 0) q.pop_front();
                    else m_under <= 1'b1;
                end
                if (bus_read && !bus_wait) begin
                    q.push_back(mem_word(bus_address));
                    addr_log.push_back(bus_address);
                    m_words <= m_words + 1;
                    m_addr  <= m_addr + 32'd1;
                end
            end
        end
    end

    // Compare process: all DUT outputs against the model on every falling edge.
    int          n_reqs = 0;
    bit          prev_read = 1'b0;
    logic [31:0] prev_addr = '0;

    always @(negedge clock) begin
        chk("fifo_level", 32'(fifo_level), 32'(q.size()));
        chk("pix_valid", 32'(pix_valid), 32'(q.size() > 0));
        if (q.size() > 0) chk("pix_data", pix_data, q[0]);
        chk("underflow", 32'(underflow), 32'(m_under));
        chk("starving", 32'(starving), 32'((q.size() <= LOW_WATER) && (m_words < WPF)));
        if (bus_read && !prev_read) begin
            n_reqs <= n_reqs + 1;
            chk("request_allowed", 32'(may_req), 32'd1);
        end
        if (bus_read && prev_read) chk("address_stable", bus_address, prev_addr);
        if (last_complete) begin
            chk("read_low_after_transfer", 32'(bus_read), 32'd0);
            chk("push_not_full", 32'(last_push_ok), 32'd1);
        end
        if (last_fs) chk("read_low_after_frame_start", 32'(bus_read), 32'd0);
        if (bus_read) chk("request_address", bus_address, m_addr);
        prev_read <= bus_read;
        prev_addr <= bus_address;
    end

    // Bus slave: wait_cfg wait cycles per read (negative = random 0..3).
    int wait_cfg = 3;
    int rem = 0;
    bit bus_prev = 1'b0;

    always @(negedge clock) begin
        if (bus_read && !bus_prev) rem = (wait_cfg < 0) ? int'($urandom_range(0, 3)) : wait_cfg;
        if (bus_read) begin
            bus_wait = (rem > 0);
            if (rem > 0) rem = rem - 1;
            bus_readdata = mem_word(bus_address);
        end else begin
            bus_wait = 1'($urandom_range(0, 1));
            bus_readdata = $urandom;
        end
        bus_prev = bus_read;
    end

    // Pixel side: 0 idle, 1 every 4th cycle, 2 random, 3 manual_rd.
    int pop_mode = 0;
    int cyc = 0;
    bit manual_rd = 1'b0;

    always @(negedge clock) begin
        cyc = cyc + 1;
        case (pop_mode)
            0:       pix_rd = 1'b0;
            1:       pix_rd = (cyc % 4 == 0);
            2:       pix_rd = ($urandom_range(0, 2) == 0);
            default: pix_rd = manual_rd;
        endcase
    end

    int log_start = 0;
    int r0 = 0;

    task automatic start_frame(input logic [31:0] base);
        fb_base     = base;
        frame_start = 1'b1;
        log_start   = addr_log.size();
        @(negedge clock);
        frame_start = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_bus_read", 32'(bus_read), 32'd0);
        chk("reset_bus_address", bus_address, 32'd0);
        chk("reset_level", 32'(fifo_level), 32'd0);
        chk("reset_pix_valid", 32'(pix_valid), 32'd0);
        chk("reset_underflow", 32'(underflow), 32'd0);
        chk("reset_starving", 32'(starving), 32'd0);
        reset_n = 1'b1;

        // Fill from 0x4000 with no pops
        enable   = 1'b1;
        wait_cfg = 3;
        pop_mode = 0;
        repeat (10) @(negedge clock);
        chk("no_fetch_before_frame_start", 32'(n_reqs), 32'd0);
        start_frame(32'h0000_4000);
        repeat (300) @(negedge clock);
        chk("t1_level_full", 32'(fifo_level), 32'd16);
        chk("t1_head_word", pix_data, 32'hA5A5_4000);
        chk("t1_word_count", 32'(addr_log.size() - log_start), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (log_start + i < addr_log.size())
                chk("t1_address", addr_log[log_start + i], 32'h4000 + 32'(i));
        end
        chk("t1_read_idle", 32'(bus_read), 32'd0);

        // Steady draining with a one-wait bus
        pop_mode = 1;
        wait_cfg = 1;
        start_frame(32'h0000_8000);
        repeat (200) @(negedge clock);
        chk("t2_word_count", 32'(addr_log.size() - log_start), 32'd20);
        chk("t2_drained", 32'(fifo_level), 32'd0);

        // Frame end at 20 words from 0x100
        wait_cfg = -1;
        start_frame(32'h0000_0100);
        repeat (250) @(negedge clock);
        chk("t3_word_count", 32'(addr_log.size() - log_start), 32'd20);
        if (addr_log.size() > 0) chk("t3_last_address", addr_log[addr_log.size() - 1], 32'h0000_0113);
        chk("t3_empty", 32'(fifo_level), 32'd0);
        chk("t3_not_starving", 32'(starving), 32'd0);
        r0 = n_reqs;
        repeat (20) @(negedge clock);
        chk("t3_no_more_reads", 32'(n_reqs), 32'(r0));

        // Abandon a stalled read with frame_start
        pop_mode = 0;
        wait_cfg = 6;
        start_frame(32'h0000_2000);
        for (int i = 0; i < 200 && !(bus_read && fifo_level >= 2); i++) @(negedge clock);
        chk("t4_request_seen", 32'(bus_read), 32'd1);
        start_frame(32'h0000_3000);
        chk("t4_read_dropped", 32'(bus_read), 32'd0);
        chk("t4_flushed", 32'(fifo_level), 32'd0);
        repeat (100) @(negedge clock);
        if (addr_log.size() > log_start) chk("t4_first_address", addr_log[log_start], 32'h0000_3000);
        chk("t4_head_word", pix_data, 32'hA5A5_3000);

        // Underflow stickiness
        pop_mode  = 3;
        manual_rd = 1'b0;
        enable    = 1'b0;
        wait_cfg  = 0;
        start_frame(32'h0000_0600);
        manual_rd = 1'b1;
        @(negedge clock);
        manual_rd = 1'b0;
        @(negedge clock);
        chk("t5_underflow_set", 32'(underflow), 32'd1);
        enable = 1'b1;
        repeat (40) @(negedge clock);
        manual_rd = 1'b1;
        repeat (2) @(negedge clock);
        manual_rd = 1'b0;
        @(negedge clock);
        chk("t5_underflow_sticky", 32'(underflow), 32'd1);
        start_frame(32'h0000_0700);
        chk("t5_underflow_cleared", 32'(underflow), 32'd0);

        // Asynchronous reset during a stalled read
        pop_mode = 2;
        wait_cfg = 8;
        start_frame(32'h0000_0500);
        for (int i = 0; i < 50 && !bus_read; i++) @(negedge clock);
        chk("t6_request_seen", 32'(bus_read), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_reset_bus_read", 32'(bus_read), 32'd0);
        chk("t6_reset_bus_address", bus_address, 32'd0);
        chk("t6_reset_level", 32'(fifo_level), 32'd0);
        chk("t6_reset_pix_valid", 32'(pix_valid), 32'd0);
        chk("t6_reset_underflow", 32'(underflow), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        r0 = n_reqs;
        repeat (30) @(negedge clock);
        chk("t6_idle_after_reset", 32'(n_reqs), 32'(r0));

        // Random frames, including address wrap and mid-frame restarts
        wait_cfg = -1;
        pop_mode = 2;
        for (int f = 0; f < 6; f++) begin
            start_frame((f == 2) ? 32'hFFFF_FFF6 : $urandom);
            for (int c = 0; c < 200; c++) begin
                enable = ($urandom_range(0, 7) != 0);
                if ($urandom_range(0, 299) == 0) begin
                    fb_base     = $urandom;
                    frame_start = 1'b1;
                end else begin
                    frame_start = 1'b0;
                end
                @(negedge clock);
            end
            frame_start = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
